// File: rtl/dedisp_channel_sum_if.sv
// dedisp_channel_sum_if
//    Bundles the channel-power stream, the detection threshold and the
//    per-spectrum results of dedisp_channel_sum.
//    Ports (signals):
//       din, din_valid, sync_in  channel stream, channel 0 flagged by sync_in
//       threshold                detection threshold, quasi-static
//       dout, dout_valid         completed spectrum sum and its one-cycle strobe
//       detect                   one-cycle candidate pulse
//       frame_err                one-cycle framing-violation pulse
//    master: stream source / result sink; slave: dedisp_channel_sum.
interface dedisp_channel_sum_if #(
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 43
);
   logic [DIN_WIDTH-1:0]  din;
   logic                  din_valid;
   logic                  sync_in;
   logic [DOUT_WIDTH-1:0] threshold;
   logic [DOUT_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  detect;
   logic                  frame_err;

   modport master (
      output din, din_valid, sync_in, threshold,
      input  dout, dout_valid, detect, frame_err
   );

   modport slave (
      input  din, din_valid, sync_in, threshold,
      output dout, dout_valid, detect, frame_err
   );
endinterface

// File: rtl/dedisp_channel_sum.sv
// dedisp_channel_sum
//    Sums N_CHANNELS consecutive dedispersed channel powers into one
//    time-series sample per spectrum, flags framing violations and raises a
//    thresholded candidate pulse with a holdoff against repeat triggers.
//    Ports:
//       clk    system clock
//       rst_n  asynchronous active-low reset
//       bus    dedisp_channel_sum_if.slave (stream in, sum/detect/frame_err out)
//
//    state   | meaning
//    --------+-----------------------------------------------------------
//    IDLE    | discarding samples, waiting for a valid sample with sync
//    ACC     | accumulating a spectrum; counter = channels taken so far
module dedisp_channel_sum #(
   parameter int DIN_WIDTH  = 32,
   parameter int N_CHANNELS = 2048,
   parameter int DOUT_WIDTH = DIN_WIDTH + $clog2(N_CHANNELS),
   parameter int HOLDOFF    = 64
) (
   input logic                clk,
   input logic                rst_n,
   dedisp_channel_sum_if.slave bus
);
   localparam int CNT_W = $clog2(N_CHANNELS);
   localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CHANNELS - 1);
   localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACC  = 1'b1;

   logic [DIN_WIDTH-1:0]  r_din;
   logic                  r_din_valid;
   logic                  r_sync;
   logic [0:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DOUT_WIDTH-1:0] r_acc;
   logic [DOUT_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;
   logic                  r_frame_err;
   logic                  r_detect;
   logic [HO_W-1:0]       r_holdoff;

   logic [DOUT_WIDTH-1:0] w_din_ext;
   logic [DOUT_WIDTH-1:0] w_sum;

   assign w_din_ext = DOUT_WIDTH'(r_din);
   assign w_sum     = r_acc + w_din_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din       <= '0;
         r_din_valid <= 1'b0;
         r_sync      <= 1'b0;
      end else begin
         r_din       <= bus.din;
         r_din_valid <= bus.din_valid;
         r_sync      <= bus.sync_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_acc        <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (r_din_valid) begin
            case (r_state)
               ST_IDLE: begin
                  if (r_sync) begin
                     r_acc   <= w_din_ext;
                     r_cnt   <= CNT_W'(1);
                     r_state <= ST_ACC;
                  end
               end
               default: begin
                  if (r_sync) begin
                     // Sync always restarts the spectrum; mid-spectrum it also
                     // drops the partial sum and reports the violation.
                     r_frame_err <= (r_cnt != '0);
                     r_acc       <= w_din_ext;
                     r_cnt       <= CNT_W'(1);
                  end else if (r_cnt == '0) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else if (r_cnt == CNT_LAST) begin
                     r_dout       <= w_sum;
                     r_dout_valid <= 1'b1;
                     r_acc        <= '0;
                     r_cnt        <= '0;
                  end else begin
                     r_acc <= w_sum;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

   // Holdoff counts completed sums, not clocks; the triggering sum reloads
   // it instead of decrementing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_detect  <= 1'b0;
         r_holdoff <= '0;
      end else begin
         r_detect <= 1'b0;
         if (r_dout_valid) begin
            if (r_holdoff != '0) begin
               r_holdoff <= r_holdoff - HO_W'(1);
            end else if (r_dout > bus.threshold) begin
               r_detect  <= 1'b1;
               r_holdoff <= HO_LOAD;
            end
         end
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;
   assign bus.detect     = r_detect;
   assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_dedisp_channel_sum.sv
module tb_dedisp_channel_sum;
   localparam int DW  = 32;
   localparam int OW  = 35;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dedisp_channel_sum_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

   dedisp_channel_sum #(
      .DIN_WIDTH(DW), .N_CHANNELS(8), .DOUT_WIDTH(OW), .HOLDOFF(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int t7 = 0;
   int n_dv = 0, n_fe = 0, n_det = 0, bad_dout = 0, lat_bad = 0;
   logic [15:0]   det_mask = '0;
   logic [OW-1:0] exp_dout = '0;
   logic [OW-1:0] last_dout = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.dout_valid === 1'b1) begin
         n_dv = n_dv + 1;
         last_dout = bus.dout;
         if (bus.dout !== exp_dout) bad_dout = bad_dout + 1;
         if (cyc - t7 != 2) lat_bad = lat_bad + 1;
      end
      if (bus.frame_err === 1'b1) n_fe = n_fe + 1;
      if (bus.detect === 1'b1) begin
         n_det = n_det + 1;
         if (n_dv < 16) det_mask[n_dv] = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clr();
      @(posedge clk);
      #1;
      n_dv = 0; n_fe = 0; n_det = 0; bad_dout = 0; lat_bad = 0;
      det_mask = '0;
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic v, input logic s);
      @(negedge clk);
      bus.din = d;
      bus.din_valid = v;
      bus.sync_in = s;
   endtask

   task automatic idle(input int n);
      repeat (n) drive('0, 1'b0, 1'b0);
   endtask

   task automatic spec(input int first, input int last, input int gapmax,
                       input bit sync0, input bit maxval);
      for (int ch = first; ch <= last; ch++) begin
         if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
         drive(maxval ? {DW{1'b1}} : DW'(ch + 1), 1'b1, sync0 && (ch == 0));
         if (ch == 7) t7 = cyc;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.sync_in = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.din = '0;
      bus.din_valid = 1'b0;
      bus.sync_in = 1'b0;
      bus.threshold = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", 64'(bus.dout), 0);
      chk("rst_dout_valid", 64'(bus.dout_valid), 0);
      chk("rst_detect", 64'(bus.detect), 0);
      chk("rst_frame_err", 64'(bus.frame_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // four back-to-back spectra
      clr();
      exp_dout = 36;
      repeat (4) spec(0, 7, 0, 1, 0);
      idle(5);
      chk("cont_count", 64'(n_dv), 4);
      chk("cont_dout_bad", 64'(bad_dout), 0);
      chk("cont_last_dout", 64'(last_dout), 36);
      chk("cont_latency_bad", 64'(lat_bad), 0);
      chk("cont_frame_err", 64'(n_fe), 0);

      // same stream with random valid gaps, forced gap before one sync
      clr();
      spec(0, 7, 5, 1, 0);
      spec(0, 7, 5, 1, 0);
      idle(2);
      spec(0, 7, 5, 1, 0);
      spec(0, 7, 5, 1, 0);
      idle(5);
      chk("gap_count", 64'(n_dv), 4);
      chk("gap_dout_bad", 64'(bad_dout), 0);
      chk("gap_latency_bad", 64'(lat_bad), 0);
      chk("gap_frame_err", 64'(n_fe), 0);

      // start mid-spectrum from IDLE
      do_reset();
      clr();
      spec(5, 7, 0, 0, 0);
      spec(0, 7, 0, 1, 0);
      idle(5);
      chk("mid_count", 64'(n_dv), 1);
      chk("mid_dout", 64'(last_dout), 36);
      chk("mid_frame_err", 64'(n_fe), 0);

      // early sync at channel 4
      clr();
      spec(0, 3, 0, 1, 0);
      spec(0, 7, 0, 1, 0);
      idle(5);
      chk("early_frame_err", 64'(n_fe), 1);
      chk("early_count", 64'(n_dv), 1);
      chk("early_dout", 64'(last_dout), 36);

      // missing sync on channel 0, then recovery
      clr();
      spec(0, 7, 0, 0, 0);
      idle(5);
      chk("nosync_frame_err", 64'(n_fe), 1);
      chk("nosync_count", 64'(n_dv), 0);
      clr();
      spec(0, 7, 0, 1, 0);
      idle(5);
      chk("recover_count", 64'(n_dv), 1);
      chk("recover_dout", 64'(last_dout), 36);
      chk("recover_frame_err", 64'(n_fe), 0);

      // detection with holdoff of 2 sums
      bus.threshold = OW'(35);
      clr();
      repeat (8) spec(0, 7, 0, 1, 0);
      idle(5);
      chk("det_count", 64'(n_det), 3);
      chk("det_which_sums", 64'(det_mask), 64'h92);
      chk("det_sum_count", 64'(n_dv), 8);
      bus.threshold = OW'(36);
      clr();
      repeat (3) spec(0, 7, 0, 1, 0);
      idle(5);
      chk("det_strict_count", 64'(n_det), 0);

      // full-scale samples, then reset in mid-spectrum
      bus.threshold = '1;
      clr();
      exp_dout = OW'(64'h7_FFFF_FFF8);
      spec(0, 7, 0, 1, 1);
      idle(5);
      chk("max_count", 64'(n_dv), 1);
      chk("max_dout", 64'(last_dout), 64'h7_FFFF_FFF8);
      chk("max_dout_bad", 64'(bad_dout), 0);
      spec(0, 3, 0, 1, 1);
      @(posedge clk);
      #2;
      chk("pre_rst_dout_held", 64'(bus.dout), 64'h7_FFFF_FFF8);
      rst_n = 1'b0;
      #1;
      chk("async_rst_dout", 64'(bus.dout), 0);
      chk("async_rst_dout_valid", 64'(bus.dout_valid), 0);
      bus.din_valid = 1'b0;
      bus.sync_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      exp_dout = 36;
      spec(0, 7, 0, 1, 0);
      idle(5);
      chk("post_rst_count", 64'(n_dv), 1);
      chk("post_rst_dout", 64'(last_dout), 36);
      chk("post_rst_frame_err", 64'(n_fe), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
